// File: rtl/umul_add_pkg.sv
// Shared constants and state encoding for the umul_add shift-add multiply-accumulate unit.
package umul_add_pkg;

    localparam int UMUL_ADD_WIDTH_A = 8;
    localparam int UMUL_ADD_WIDTH_B = 4;
    localparam int UMUL_ADD_PROD_W  = UMUL_ADD_WIDTH_A + UMUL_ADD_WIDTH_B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/umul_add.sv
// Sequential unsigned A*B+C, one multiplier bit per RUN cycle (inverse of a restoring divider).
// Optional UMUL_ADD_EARLY_EXIT_EN: leave RUN once the remaining multiplier bits are all zero.
module umul_add
    import umul_add_pkg::*;
#(
    parameter int WIDTH_A = UMUL_ADD_WIDTH_A,
    parameter int WIDTH_B = UMUL_ADD_WIDTH_B
) (
    input  logic                       CLK,
    input  logic                       iRESET_N,
    input  logic                       iMULVLD,
    input  logic [WIDTH_A-1:0]         iMULTIPLICAND,
    input  logic [WIDTH_B-1:0]         iMULTIPLIER,
    input  logic [WIDTH_B-1:0]         iADDEND,
    output logic [WIDTH_A+WIDTH_B-1:0] oPRODUCT,
    output logic                       oDONE,
    output logic                       oBUSY,
    output state_e                     oSTATE
);

    localparam int PW = WIDTH_A + WIDTH_B;
    localparam int CW = (WIDTH_B > 1) ? $clog2(WIDTH_B) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH_B - 1);

    state_e             state_q, state_d;
    logic               mulvld_q, mulvld_d;
    logic [WIDTH_A-1:0] a_q, a_d;
    logic [WIDTH_B-1:0] b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [PW-1:0]      product_q, product_d;
    logic               done_q, done_d;

    logic               start;
    logic               last_iter;
    logic [PW-1:0]      a_shift;
`ifdef UMUL_ADD_EARLY_EXIT_EN
    logic [WIDTH_B-1:0] b_rest;
`endif

    always_comb begin
        start   = iMULVLD & ~mulvld_q & (state_q == ST_IDLE);
        a_shift = PW'(a_q) << cnt_q;
`ifdef UMUL_ADD_EARLY_EXIT_EN
        // Multiplier bits strictly above the one consumed this cycle.
        b_rest    = (b_q >> cnt_q) >> 1;
        last_iter = (cnt_q == LAST_IDX) || (b_rest == '0);
`else
        last_iter = (cnt_q == LAST_IDX);
`endif
    end

    always_comb begin
        state_d   = state_q;
        mulvld_d  = iMULVLD;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d   = iMULTIPLICAND;
                    b_d   = iMULTIPLIER;
                    acc_d = PW'(iADDEND);
                    cnt_d = '0;
`ifdef UMUL_ADD_EARLY_EXIT_EN
                    state_d = (iMULTIPLIER == '0) ? ST_DONE : ST_RUN;
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                if (b_q[cnt_q]) begin
                    acc_d = acc_q + a_shift;
                end
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                product_d = acc_q;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            state_q   <= ST_IDLE;
            mulvld_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mulvld_q  <= mulvld_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign oPRODUCT = product_q;
    assign oDONE    = done_q;
    assign oBUSY    = (state_q != ST_IDLE);
    assign oSTATE   = state_q;

endmodule

// File: tb/tb_umul_add.sv
// Scoreboard bench for umul_add: directed corner cases plus an A x B sweep with random C < B.
module tb_umul_add;
    import umul_add_pkg::*;

    localparam int WA = 8;
    localparam int WB = 4;
    localparam int PW = WA + WB;

    logic          CLK = 1'b0;
    logic          iRESET_N = 1'b0;
    logic          iMULVLD = 1'b0;
    logic [WA-1:0] iMULTIPLICAND = '0;
    logic [WB-1:0] iMULTIPLIER = '0;
    logic [WB-1:0] iADDEND = '0;
    logic [PW-1:0] oPRODUCT;
    logic          oDONE;
    logic          oBUSY;
    state_e        dbg_state;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int done_cnt  = 0;
    logic [PW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    umul_add #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
        .CLK           (CLK),
        .iRESET_N      (iRESET_N),
        .iMULVLD       (iMULVLD),
        .iMULTIPLICAND (iMULTIPLICAND),
        .iMULTIPLIER   (iMULTIPLIER),
        .iADDEND       (iADDEND),
        .oPRODUCT      (oPRODUCT),
        .oDONE         (oDONE),
        .oBUSY         (oBUSY),
        .oSTATE        (dbg_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [WB-1:0] b);
        int lat;
        lat = WB + 1;
`ifdef UMUL_ADD_EARLY_EXIT_EN
        lat = 1;
        for (int i = 0; i < WB; i++) begin
            if (b[i]) lat = i + 2;
        end
`endif
        return lat;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(posedge CLK) begin
        #1;
        if (oDONE === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_done", 32'(oDONE), 32'(0));
            end else begin
                check_eq("product", 32'(oPRODUCT), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic launch(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic [WB-1:0] c);
        iMULTIPLICAND = a;
        iMULTIPLIER   = b;
        iADDEND       = c;
        iMULVLD       = 1'b1;
        exp_q.push_back(PW'(int'(a) * int'(b) + int'(c)));
    endtask

    task automatic wait_done(input int lat, input bit drop);
        int n0;
        int cyc;
        n0 = done_cnt;
        @(negedge CLK);
        cyc = 1;
        check_eq("busy_during_op", 32'(oBUSY), 32'(1));
        while (done_cnt == n0 && cyc < 40) begin
            @(negedge CLK);
            cyc++;
        end
        check_eq("done_seen", 32'(done_cnt - n0), 32'(1));
        if (done_cnt != n0) begin
            check_eq("latency", 32'(cyc - 1), 32'(lat));
            check_eq("busy_after_done", 32'(oBUSY), 32'(0));
        end
        if (drop) iMULVLD = 1'b0;
    endtask

    task automatic op(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic [WB-1:0] c);
        @(negedge CLK);
        launch(a, b, c);
        wait_done(exp_lat(b), 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0;

        repeat (3) @(negedge CLK);
        check_eq("rst_product", 32'(oPRODUCT), 32'(0));
        check_eq("rst_done", 32'(oDONE), 32'(0));
        check_eq("rst_busy", 32'(oBUSY), 32'(0));
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        iRESET_N = 1'b1;

        op(8'd255, 4'd15, 4'd14);
        op(8'd254, 4'd3, 4'd2);
        repeat (4) @(negedge CLK);
        check_eq("product_hold", 32'(oPRODUCT), 32'(764));
        op(8'd0, 4'd0, 4'd0);

        // Second rising edge while busy, operands scrambled after the start edge.
        @(negedge CLK);
        n0 = done_cnt;
        launch(8'd100, 4'd9, 4'd1);
        @(negedge CLK);
        iMULVLD       = 1'b0;
        iMULTIPLICAND = 8'($urandom_range(255, 0));
        iMULTIPLIER   = 4'($urandom_range(15, 0));
        iADDEND       = 4'($urandom_range(15, 0));
        @(negedge CLK);
        iMULVLD = 1'b1;
        repeat (14) @(negedge CLK);
        check_eq("drop_one_done", 32'(done_cnt - n0), 32'(1));
        check_eq("drop_product", 32'(oPRODUCT), 32'(901));
        iMULVLD = 1'b0;

        // Reset mid-operation aborts with no done pulse.
        @(negedge CLK);
        iMULTIPLICAND = 8'd255;
        iMULTIPLIER   = 4'd15;
        iADDEND       = 4'd0;
        iMULVLD       = 1'b1;
        repeat (3) @(negedge CLK);
        iRESET_N = 1'b0;
        #1;
        check_eq("abort_product", 32'(oPRODUCT), 32'(0));
        check_eq("abort_busy", 32'(oBUSY), 32'(0));
        check_eq("abort_done", 32'(oDONE), 32'(0));
        n0 = done_cnt;
        repeat (8) @(negedge CLK);
        check_eq("abort_no_done", 32'(done_cnt - n0), 32'(0));
        iRESET_N = 1'b1;
        launch(8'd255, 4'd15, 4'd0);
        wait_done(exp_lat(4'd15), 1'b1);

        // Request held high for 20 cycles starts exactly once.
        @(negedge CLK);
        n0 = done_cnt;
        launch(8'd17, 4'd5, 4'd3);
        repeat (20) @(negedge CLK);
        iMULVLD = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("hold_one_done", 32'(done_cnt - n0), 32'(1));
        check_eq("hold_product", 32'(oPRODUCT), 32'(88));

        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                op(8'(a), 4'(b), 4'($urandom_range(b - 1, 0)));
            end
        end

        repeat (4) @(negedge CLK);
        check_eq("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
